// File: rtl/fft_pkg.sv
// Shared constants, write-side FSM encoding and the index bit-reversal helper
// for the 16-point FFT input stage.
package fft_pkg;

  localparam int FFT_DATA_W = 16;
  localparam int FFT_N      = 16;
  localparam int FFT_LOG2N  = $clog2(FFT_N);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } wr_state_e;

  // Reverses the low nbits bits of idx. The result always fits in nbits bits.
  function automatic int unsigned bitrev(input int unsigned idx,
                                         input int unsigned nbits = FFT_LOG2N);
    int unsigned r;
    r = 0;
    for (int b = 0; b < 32; b++) begin
      if (b < int'(nbits) && idx[b]) begin
        r = r | (32'd1 << (int'(nbits) - 1 - b));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample stream, frame handshake and parallel frame bus between the sample
// source / butterfly core and the frame loader.
interface fft_frame_loader_if
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N      = FFT_N
);

  logic                s_valid;
  logic                s_ready;
  logic [DATA_W-1:0]   s_real;
  logic [DATA_W-1:0]   s_imag;
  logic                s_last;
  logic                frame_done;
  logic                new_input_flag;
  logic [N*DATA_W-1:0] o_frame_real;
  logic [N*DATA_W-1:0] o_frame_imag;
  logic                frame_err;

  modport master (
    output s_valid, s_real, s_imag, s_last, frame_done,
    input  s_ready, new_input_flag, o_frame_real, o_frame_imag, frame_err
  );

  modport slave (
    input  s_valid, s_real, s_imag, s_last, frame_done,
    output s_ready, new_input_flag, o_frame_real, o_frame_imag, frame_err
  );

endinterface

// File: rtl/fft_frame_bank.sv
// One frame buffer: N complex slots, single write port, async clear and
// every slot visible at once on a flat parallel read bus.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N      = FFT_N,
  parameter int AW     = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wr_real,
  input  logic [DATA_W-1:0]   wr_imag,
  output logic [N*DATA_W-1:0] rd_real,
  output logic [N*DATA_W-1:0] rd_imag
);

  logic [DATA_W-1:0] mem_real [N];
  logic [DATA_W-1:0] mem_imag [N];

  // NOTE: this array is reset on purpose -- the bank drives the output frame
  // directly, so it must read as zeros after reset instead of stale contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem_real[i] <= '0;
        mem_imag[i] <= '0;
      end
    end else if (we) begin
      mem_real[addr] <= wr_real;
      mem_imag[addr] <= wr_imag;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rd_real[i*DATA_W +: DATA_W] = mem_real[i];
      rd_imag[i*DATA_W +: DATA_W] = mem_imag[i];
    end
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader: fills one bank from the sample stream while the
// other bank is presented to the butterflies, swapping on frame boundaries.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N      = FFT_N,
  parameter int BITREV = 0
) (
  input  logic             clk,
  input  logic             rst,
  fft_frame_loader_if.slave bus
);

  localparam int AW = $clog2(N);

  wr_state_e           state;
  wr_state_e           state_next;
  logic [AW-1:0]       wr_cnt;
  logic [AW-1:0]       wr_addr;
  logic                wr_bank;
  logic                rd_busy;
  logic                wr_full;
  logic                flag_q;
  logic                err_q;

  logic                accept;
  logic                at_last;
  logic                misalign;
  logic                frame_complete;
  logic                swap;
  logic                we0;
  logic                we1;
  logic [N*DATA_W-1:0] b0_real, b0_imag, b1_real, b1_imag;

  always_comb begin
    accept         = bus.s_valid && bus.s_ready;
    at_last        = accept && (wr_cnt == AW'(N - 1));
    misalign       = accept && bus.s_last && (wr_cnt != AW'(N - 1));
    frame_complete = at_last || wr_full;
    // The reading bank is released either already or by frame_done this cycle.
    swap           = frame_complete && (!rd_busy || bus.frame_done);
    wr_addr        = (BITREV != 0) ? AW'(bitrev(32'(wr_cnt), AW)) : wr_cnt;
    // A misaligned sample is dropped together with the partial frame.
    we0            = accept && !misalign && !wr_bank;
    we1            = accept && !misalign &&  wr_bank;
  end

  // Write-side FSM: FILL accepts samples, FULL holds a finished frame until
  // the reading bank frees up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FILL;
    else     state <= state_next;
  end

  // NOTE: default assignment first so that no path through the case leaves
  // state_next unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_FILL:  if (at_last && !swap) state_next = S_FULL;
      S_FULL:  if (swap)             state_next = S_FILL;
      default:                       state_next = S_FILL;
    endcase
  end

  always_comb begin
    wr_full     = (state == S_FULL);
    bus.s_ready = !wr_full && !rst;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop here
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_busy <= 1'b0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (swap || misalign || at_last) wr_cnt <= '0;
      else if (accept)                 wr_cnt <= wr_cnt + 1'b1;

      if (swap) wr_bank <= !wr_bank;

      if (swap)                rd_busy <= 1'b1;
      else if (bus.frame_done) rd_busy <= 1'b0;

      flag_q <= swap;

      if (misalign || (at_last && !bus.s_last)) err_q <= 1'b1;
    end
  end

  fft_frame_bank #(.DATA_W(DATA_W), .N(N), .AW(AW)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (we0),
    .addr    (wr_addr),
    .wr_real (bus.s_real),
    .wr_imag (bus.s_imag),
    .rd_real (b0_real),
    .rd_imag (b0_imag)
  );

  fft_frame_bank #(.DATA_W(DATA_W), .N(N), .AW(AW)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (we1),
    .addr    (wr_addr),
    .wr_real (bus.s_real),
    .wr_imag (bus.s_imag),
    .rd_real (b1_real),
    .rd_imag (b1_imag)
  );

  // Present whichever bank is not being written.
  assign bus.o_frame_real   = wr_bank ? b0_real : b1_real;
  assign bus.o_frame_imag   = wr_bank ? b0_imag : b1_imag;
  assign bus.new_input_flag = flag_q;
  assign bus.frame_err      = err_q;

endmodule
